// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer for the memory stage: valid/grant/rvalid bus, pipeline stall,
// load formatting. Optional watchdog enabled by defining DM_TIMEOUT_EN.
module dm_access_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m_mem_read,
  input  logic            m_mem_write,
  input  logic [2:0]      m_funct3,
  input  logic [XLEN-1:0] m_addr,
  input  logic [XLEN-1:0] m_wdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            access_err,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [3:0]      r_bus_be;
  logic [XLEN-1:0] r_bus_wdata;
  logic [2:0]      r_funct3;
  logic [1:0]      r_lane;
  logic [XLEN-1:0] r_load_data;
  logic            r_load_valid;
  logic            r_access_err;
  logic            w_access;
  logic            w_legal;
  logic            w_tmo_hit;
  logic            w_done_load;
  logic            w_done_err;
  logic            w_done_tmo;

  function automatic logic f_legal(input logic [2:0] f3, input logic [1:0] lane);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~lane[0];
      3'b010:         ok = (lane == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      3'b000, 3'b100: be = 4'b0001 << lane;
      3'b001, 3'b101: be = 4'b0011 << {lane[1], 1'b0};
      3'b010:         be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] f_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] res;
    case (f3[1:0])
      2'b00:   res = {4{d[7:0]}};
      2'b01:   res = {2{d[15:0]}};
      default: res = d;
    endcase
    return res;
  endfunction

  function automatic logic [XLEN-1:0] f_fmt(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [XLEN-1:0] d);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res = {{(XLEN-8){b[7]}}, b};
      3'b100:  res = {{(XLEN-8){1'b0}}, b};
      3'b001:  res = {{(XLEN-16){h[15]}}, h};
      3'b101:  res = {{(XLEN-16){1'b0}}, h};
      3'b010:  res = d;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  assign w_access = m_mem_read | m_mem_write;
  assign w_legal  = (m_mem_read ^ m_mem_write) & f_legal(m_funct3, m_addr[1:0]);

  // Next-state, stall and completion-cause decode
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_done_load = 1'b0;
    w_done_err  = 1'b0;
    w_done_tmo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          stall = 1'b1;
          if (w_legal) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DONE;
            w_done_err  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_gnt && r_bus_we) begin
          w_state_nxt = S_DONE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
          w_done_tmo  = 1'b1;
        end else if (bus_gnt) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          w_state_nxt = S_DONE;
          w_done_load = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
          w_done_tmo  = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus request registers, captured once per access and held until the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= {XLEN{1'b0}};
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= {XLEN{1'b0}};
      r_funct3    <= 3'b000;
      r_lane      <= 2'b00;
    end else if ((r_state == S_IDLE) && w_access) begin
      r_bus_we    <= m_mem_write;
      r_bus_addr  <= {m_addr[XLEN-1:2], 2'b00};
      r_bus_be    <= f_be(m_funct3, m_addr[1:0]);
      r_bus_wdata <= f_wdata(m_funct3, m_wdata);
      r_funct3    <= m_funct3;
      r_lane      <= m_addr[1:0];
    end
  end

  // Writeback results; pulses line up with the single DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_data  <= {XLEN{1'b0}};
      r_load_valid <= 1'b0;
      r_access_err <= 1'b0;
    end else begin
      r_load_valid <= w_done_load;
      r_access_err <= w_done_err;
      if (w_done_load) begin
        r_load_data <= f_fmt(r_funct3, r_lane, bus_rdata);
      end else if (w_done_err || w_done_tmo) begin
        r_load_data <= {XLEN{1'b0}};
      end
    end
  end

`ifdef DM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_timeout_err;

  // Watchdog: zero outside an access, so it restarts on every REQ entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt     <= {CW{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_done_tmo;
      if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_tmo_cnt <= r_tmo_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_tmo_cnt <= {CW{1'b0}};
      end
    end
  end

  assign w_tmo_hit   = ((r_state == S_REQ) || (r_state == S_WAIT)) && (r_tmo_cnt == TMO_LAST);
  assign timeout_err = r_timeout_err;
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign w_tmo_hit        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign bus_req    = (r_state == S_REQ);
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_be     = r_bus_be;
  assign bus_wdata  = r_bus_wdata;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign access_err = r_access_err;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed vector table, reset corner case,
// optional watchdog case, and randomized accesses against a behavioural model.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_mem_read, m_mem_write;
  logic [2:0]  m_funct3;
  logic [31:0] m_addr, m_wdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, access_err, timeout_err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_ld;

  always #5 clk = ~clk;

  dm_access_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .m_funct3(m_funct3),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .access_err(access_err), .timeout_err(timeout_err)
  );

  typedef struct {
    int          stall_cnt;
    int          req_cnt;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    bit          unstable;
    int          lv_cnt;
    int          ae_cnt;
    int          te_cnt;
    logic [31:0] ld_pulse;
    logic [31:0] ld_final;
    bit          hung;
  } res_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdel;
    int          rvdel;
    bit          junk;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
    bit          exp_err;
    int          exp_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access rules computed from size and alignment arithmetic
  function automatic int unsigned m_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr);
    int unsigned s = m_size(f3);
    if (rd == wr || s == 0) return 1'b0;
    return (addr % s) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [7:0] t;
    t = 8'(((32'd1 << m_size(f3)) - 32'd1) << (addr % 4));
    return t[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] o;
    int unsigned s = m_size(f3);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % s) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int unsigned s = m_size(f3);
    int unsigned bits = 8 * s;
    logic [31:0] sh, mask, v;
    sh   = rdata >> (8 * (addr % 4));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v    = sh & mask;
    if (!f3[2] && s < 4 && sh[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Runs one access starting right at a falling edge; ends just after the post-DONE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int gdel, input int rvdel,
                           input bit junk, output res_t r);
    int c = 0;
    int post = -1;
    int gcyc = 0;
    bit granted = 1'b0;
    bit fin = 1'b0;
    r = '{default: '0};
    m_mem_read = rd; m_mem_write = wr; m_funct3 = f3; m_addr = addr; m_wdata = wdata;
    while (!fin && c < 300) begin
      #1;
      if (stall) r.stall_cnt++;
      if (load_valid) begin r.lv_cnt++; r.ld_pulse = load_data; end
      if (access_err) r.ae_cnt++;
      if (timeout_err) r.te_cnt++;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hBAD0_BAD0;
      if (post >= 0) begin
        r.ld_final = load_data;
        bus_rvalid = junk;
        fin = 1'b1;
      end else begin
        if (bus_req) begin
          if (r.req_cnt == 0) begin
            r.be = bus_be; r.addr = bus_addr; r.wd = bus_wdata; r.we = bus_we;
          end else if (bus_be !== r.be || bus_addr !== r.addr || bus_wdata !== r.wd ||
                       bus_we !== r.we) begin
            r.unstable = 1'b1;
          end
          r.req_cnt++;
          if (r.req_cnt - 1 == gdel) begin
            bus_gnt = 1'b1; granted = 1'b1; gcyc = c;
          end else begin
            bus_rvalid = junk;
          end
        end
        if (granted && rd && !wr && c - gcyc == rvdel && rvdel > 0) begin
          bus_rvalid = 1'b1; bus_rdata = rdata;
        end
        if (!stall) begin
          post = c;
          m_mem_read = 1'b0; m_mem_write = 1'b0;
          bus_rvalid = junk;
        end
      end
      @(negedge clk);
      c++;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    r.hung = !fin;
  endtask

  task automatic check_txn(input string tag, input res_t r, input logic rd, input logic wr,
                           input logic [31:0] addr, input int gdel, input logic [3:0] e_be,
                           input logic [31:0] e_wd, input logic [31:0] e_ld, input bit e_err,
                           input int e_stall);
    chk({tag, ".hung"}, r.hung, 0);
    chk({tag, ".stall_cycles"}, r.stall_cnt, e_stall);
    chk({tag, ".req_cycles"}, r.req_cnt, e_err ? 0 : gdel + 1);
    chk({tag, ".access_err"}, r.ae_cnt, e_err ? 1 : 0);
    chk({tag, ".load_valid"}, r.lv_cnt, (!e_err && rd) ? 1 : 0);
    chk({tag, ".timeout_err"}, r.te_cnt, 0);
    chk({tag, ".load_data"}, r.ld_final, e_ld);
    if (!e_err) begin
      chk({tag, ".bus_be"}, r.be, e_be);
      chk({tag, ".bus_addr"}, r.addr, addr & 32'hFFFF_FFFC);
      chk({tag, ".bus_we"}, r.we, wr);
      chk({tag, ".stable"}, r.unstable, 0);
      if (wr) chk({tag, ".bus_wdata"}, r.wd, e_wd);
      if (rd) chk({tag, ".pulse_data"}, r.ld_pulse, e_ld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "tb watchdog");
  end

  initial begin
    res_t r;
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 3};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFF00, 0, 1, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFF00, 0, 1, 1'b1, 4'b1000, 32'h0, 32'h00000080, 1'b0, 3};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FFFF00, 0, 1, 1'b0, 4'b1100, 32'h0, 32'h000080FF, 1'b0, 3};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h306, 32'h1234ABCD, 32'h0, 4, 0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h000080FF, 1'b0, 6};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80FFFF00, 1, 2, 1'b0, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0, 5};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0, 0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'hFFFF80FF, 1'b0, 2};
    vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h000, 32'h0, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    vecs[10] = '{1'b1, 1'b0, 3'b101, 32'h201, 32'h0, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0, 1, 1'b0, 4'b0010, 32'h0, 32'h0000007F, 1'b0, 3};
    vecs[12] = '{1'b0, 1'b1, 3'b010, 32'h040, 32'hCAFEF00D, 32'h0, 0, 0, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0000007F, 1'b0, 2};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h008, 32'h0, 32'h12345678, 2, 3, 1'b1, 4'b1111, 32'h0, 32'h12345678, 1'b0, 7};

    reset = 1'b1; m_mem_read = 1'b0; m_mem_write = 1'b0; m_funct3 = 3'b000;
    m_addr = 32'h0; m_wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.bus_req", bus_req, 0);
    chk("reset.bus_we", bus_we, 0);
    chk("reset.bus_be", bus_be, 0);
    chk("reset.bus_addr", bus_addr, 0);
    chk("reset.bus_wdata", bus_wdata, 0);
    chk("reset.load_data", load_data, 0);
    chk("reset.pulses", {load_valid, access_err, timeout_err}, 0);
    chk("reset.stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("stale_rvalid.load_valid", load_valid, 0);
    chk("stale_rvalid.bus_req", bus_req, 0);
    model_ld = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                vecs[i].gdel, vecs[i].rvdel, vecs[i].junk, r);
      check_txn($sformatf("vec%0d", i), r, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].gdel,
                vecs[i].exp_be, vecs[i].exp_wd, vecs[i].exp_ld, vecs[i].exp_err, vecs[i].exp_stall);
    end
    model_ld = vecs[13].exp_ld;

    // Reset while waiting for read data; the late response must be dropped
    m_mem_read = 1'b1; m_funct3 = 3'b010; m_addr = 32'h10;
    #1;
    chk("rst_wait.idle_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("rst_wait.req", bus_req, 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    chk("rst_wait.wait_state", {bus_req, stall}, 2'b01);
    reset = 1'b1; m_mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wait.bus_req", bus_req, 0);
    chk("rst_wait.stall", stall, 0);
    chk("rst_wait.bus_addr", bus_addr, 0);
    bus_rvalid = 1'b1; bus_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("rst_wait.no_load_valid", load_valid, 0);
    chk("rst_wait.load_data", load_data, 0);
    chk("rst_wait.idle_after", {bus_req, stall}, 2'b00);
    model_ld = 32'h0;
    @(negedge clk);

`ifdef DM_TIMEOUT_EN
    do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 255, 1, 1'b1, r);
    chk("tmo.hung", r.hung, 0);
    chk("tmo.timeout_err", r.te_cnt, 1);
    chk("tmo.req_cycles", r.req_cnt, 8);
    chk("tmo.stall_cycles", r.stall_cnt, 9);
    chk("tmo.load_valid", r.lv_cnt, 0);
    chk("tmo.load_data", r.ld_final, 0);
    model_ld = 32'h0;
`endif

    for (int n = 0; n < 40; n++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rdv, e_ld;
      int          sel, gdel, rvdel, e_stall;
      bit          junk, lg;
      logic [2:0]  f3_tab[5];
      f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      sel = $urandom_range(0, 9);
      rd = (sel <= 4) || (sel == 9);
      wr = (sel >= 5);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : f3_tab[$urandom_range(0, 4)];
      addr = $urandom; wd = $urandom; rdv = $urandom;
      gdel = $urandom_range(0, 3); rvdel = $urandom_range(1, 3);
      junk = 1'($urandom_range(0, 1));
      lg = m_legal(rd, wr, f3, addr);
      if (!lg) model_ld = 32'h0;
      else if (rd) model_ld = m_load(f3, addr, rdv);
      e_ld = model_ld;
      e_stall = !lg ? 1 : (wr ? gdel + 2 : gdel + 2 + rvdel);
      do_access(rd, wr, f3, addr, wd, rdv, gdel, rvdel, junk, r);
      check_txn($sformatf("rand%0d", n), r, rd, wr, addr, gdel, m_be(f3, addr), m_wd(f3, wd),
                e_ld, !lg, e_stall);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
